// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and helpers for the multi-port register file.
//   DATA_W_DEF / NREGS_DEF : default register width and register count
//   ZERO_REG               : index of the hardwired-zero register
//   aw_of()                : address width for a given register count
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned ZERO_REG   = 0;

  function automatic int unsigned aw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: per-register busy bits plus a running busy count.
//   clk_i, rst_i : clock, synchronous active-high reset
//   set_i        : registers reserved this cycle (set wins over clear)
//   clr_i        : registers written this cycle
//   busy_o       : stored busy vector
//   cnt_o        : registered popcount of busy_o
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = aw_of(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREGS-1:0] set_i,
  input  logic [NREGS-1:0] clr_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] rise, fall;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW:0]      n_rise, n_fall;

  always_comb begin
    busy_d = (busy_q & ~clr_i) | set_i;
    // Only real transitions move the count; re-set or re-clear is a no-op.
    rise   = set_i & ~busy_q;
    fall   = clr_i & ~set_i & busy_q;
    n_rise = '0;
    n_fall = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      n_rise = n_rise + (AW+1)'(rise[r]);
      n_fall = n_fall + (AW+1)'(fall[r]);
    end
    cnt_d = cnt_q + n_rise - n_fall;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with integrated busy-bit scoreboard.
//   Clk, reset : clock, synchronous active-high reset
//   rd_addr    : NRD read addresses; rd_data / rd_busy combinational results
//   wr_en, wr_addr, wr_data : NWR write ports, highest index wins on conflict
//   rsv_en, rsv_addr        : mark a destination register pending
//   busy_cnt   : registered number of busy registers
// Register 0 reads zero and is never busy.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data and busy-clear
// to the read ports; otherwise reads come purely from stored state.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned NWR    = 1,
  localparam int unsigned AW     = aw_of(NREGS)
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic [AW:0]           busy_cnt
);

  logic [DATA_W-1:0] gpr_q [NREGS];
  logic [NREGS-1:0]  set_mask, clr_mask;
  logic [NREGS-1:0]  busy;
  logic [AW-1:0]     rd_a [NRD];

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG)))
        clr_mask[wr_addr[j*AW +: AW]] = 1'b1;
    end
    if (rsv_en && (rsv_addr != AW'(ZERO_REG)))
      set_mask[rsv_addr] = 1'b1;
  end

  // Ascending port order: the last non-blocking assignment (highest port) wins.
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++)
        gpr_q[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG)))
          gpr_q[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  regfile_mp_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk_i  (Clk),
    .rst_i  (reset),
    .set_i  (set_mask),
    .clr_i  (clr_mask),
    .busy_o (busy),
    .cnt_o  (busy_cnt)
  );

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++)
      rd_a[i] = rd_addr[i*AW +: AW];
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (rd_a[i] != AW'(ZERO_REG)) begin
        rd_data[i*DATA_W +: DATA_W] = gpr_q[rd_a[i]];
        rd_busy[i]                  = busy[rd_a[i]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int unsigned j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_a[i]))
            rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
        if (clr_mask[rd_a[i]] && !set_mask[rd_a[i]])
          rd_busy[i] = 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          Clk = 1'b0;
  logic          reset;
  logic [9:0]    rd_addr;
  logic [63:0]   rd_data;
  logic [1:0]    rd_busy;
  logic [1:0]    wr_en;
  logic [9:0]    wr_addr;
  logic [63:0]   wr_data;
  logic          rsv_en;
  logic [4:0]    rsv_addr;
  logic [5:0]    busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(
    .DATA_W (32),
    .NREGS  (32),
    .NRD    (2),
    .NWR    (2)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_addr = '0; idle();
    tick(); tick();
    reset = 1'b0;
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt_init: got %0d expected 0", busy_cnt); end
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick(); idle();
    rd_addr = {5'd6, 5'd5}; #1;
    n_tests++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_pre_data: got %h expected DEADBEEF", rd_data[31:0]); end
    n_tests++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL reset_pre_cnt: got %0d expected 1", busy_cnt); end
    // reset with concurrent write and reserve: both must be discarded
    reset = 1'b1;
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h11111111;
    rsv_en = 1'b1; rsv_addr = 5'd8;
    tick(); reset = 1'b0; idle(); #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd_data[31:0]); end
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
    n_tests++;
    if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL reset_busy6: got %b expected 0", rd_busy[1]); end
    rd_addr = {5'd8, 5'd5}; #1;
    n_tests++;
    if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", rd_busy[1]); end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h0BADF00D;
    tick();
    wr_data[31:0] = 32'h12345678;
    rd_addr = {5'd4, 5'd3}; #1;
    n_tests++;
    if (rd_data[31:0] !== (BYP ? 32'h12345678 : 32'h0BADF00D)) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data[31:0], BYP ? 32'h12345678 : 32'h0BADF00D);
    end
    n_tests++;
    if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL bypass_other_port: got %h expected 0", rd_data[63:32]); end
    tick(); idle(); #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL bypass_next_cycle: got %h expected 12345678", rd_data[31:0]); end
  endtask

  task automatic test_port_priority();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd7; tick();
    rsv_addr = 5'd10; tick(); idle(); #1;
    n_tests++;
    if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL prio_cnt_pre: got %0d expected 2", busy_cnt); end
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h0000BBBB, 32'h0000AAAA};
    rd_addr = {5'd7, 5'd7}; #1;
    n_tests++;
    if (rd_data[31:0] !== (BYP ? 32'h0000BBBB : 32'h0)) begin
      n_fail++; $display("FAIL prio_bypass_data: got %h expected %h", rd_data[31:0], BYP ? 32'h0000BBBB : 32'h0);
    end
    n_tests++;
    if (rd_busy[0] !== !BYP) begin n_fail++; $display("FAIL prio_bypass_busy: got %b expected %b", rd_busy[0], !BYP); end
    tick(); idle(); #1;
    n_tests++;
    if (rd_data[63:32] !== 32'h0000BBBB) begin n_fail++; $display("FAIL prio_data: got %h expected 0000BBBB", rd_data[63:32]); end
    n_tests++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL prio_cnt: got %0d expected 1", busy_cnt); end
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %b expected 0", rd_busy[0]); end
    wr_en = 2'b10; wr_addr = {5'd10, 5'd0}; wr_data = {32'h0000A0A0, 32'h0};
    tick(); idle(); rd_addr = {5'd10, 5'd7}; #1;
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL prio_cleanup_cnt: got %0d expected 0", busy_cnt); end
    n_tests++;
    if (rd_data[63:32] !== 32'h0000A0A0) begin n_fail++; $display("FAIL prio_port1_data: got %h expected 0000A0A0", rd_data[63:32]); end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle(); rd_addr = {5'd0, 5'd9}; #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set: got %b expected 1", rd_busy[0]); end
    n_tests++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt_set: got %0d expected 1", busy_cnt); end
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle(); #1;
    n_tests++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt_reset_same: got %0d expected 1", busy_cnt); end
    wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h00000099; #1;
    n_tests++;
    if (rd_busy[0] !== !BYP) begin n_fail++; $display("FAIL sb_busy_bypass: got %b expected %b", rd_busy[0], !BYP); end
    tick(); idle(); #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clr: got %b expected 0", rd_busy[0]); end
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_cnt_clr: got %0d expected 0", busy_cnt); end
    n_tests++;
    if (rd_data[31:0] !== 32'h00000099) begin n_fail++; $display("FAIL sb_data: got %h expected 00000099", rd_data[31:0]); end
    wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h00000099;
    tick(); idle(); #1;
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_cnt_clr_idle: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_rsv_and_write();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h00005A5A;
    rd_addr = {5'd0, 5'd9}; #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rw_busy_comb: got %b expected 1", rd_busy[0]); end
    n_tests++;
    if (rd_data[31:0] !== (BYP ? 32'h00005A5A : 32'h00000099)) begin
      n_fail++; $display("FAIL rw_data_comb: got %h expected %h", rd_data[31:0], BYP ? 32'h00005A5A : 32'h00000099);
    end
    tick(); idle(); #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rw_busy: got %b expected 1", rd_busy[0]); end
    n_tests++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL rw_cnt: got %0d expected 1", busy_cnt); end
    n_tests++;
    if (rd_data[31:0] !== 32'h00005A5A) begin n_fail++; $display("FAIL rw_data: got %h expected 00005A5A", rd_data[31:0]); end
    wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h00005A5A;
    tick(); idle(); #1;
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rw_cleanup_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_reg0();
    idle();
    wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd0}; #1;
    n_tests++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL r0_data_comb: got %h expected 0", rd_data); end
    tick(); idle(); #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL r0_data: got %h expected 0", rd_data[31:0]); end
    n_tests++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL r0_busy: got %b expected 00", rd_busy); end
    n_tests++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL r0_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_multi_clear();
    idle();
    rsv_en = 1'b1;
    rsv_addr = 5'd1; tick();
    rsv_addr = 5'd2; tick();
    rsv_addr = 5'd3; tick();
    idle(); #1;
    n_tests++;
    if (busy_cnt !== 6'd3) begin n_fail++; $display("FAIL multi_cnt3: got %0d expected 3", busy_cnt); end
    wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'h22222222, 32'h11111111};
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick(); idle(); rd_addr = {5'd4, 5'd3}; #1;
    n_tests++;
    if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL multi_cnt2: got %0d expected 2", busy_cnt); end
    n_tests++;
    if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL multi_busy: got %b expected 11", rd_busy); end
    rd_addr = {5'd2, 5'd1}; #1;
    n_tests++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL multi_busy_clr: got %b expected 00", rd_busy); end
    n_tests++;
    if (rd_data !== {32'h22222222, 32'h11111111}) begin
      n_fail++; $display("FAIL multi_data: got %h expected 2222222211111111", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_port_priority();
    test_scoreboard();
    test_rsv_and_write();
    test_reg0();
    test_multi_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
